decode_cycle: RTL

- Instruction-decode stage of the 5-stage pipelined MIPS-subset core.
- Consumes the IF/ID pipeline register outputs (InstructionD, PCPlus4D) produced by the fetch stage.
- Contains the register file, writes it from the writeback stage, and generates control signals and the sign-extended immediate.
- Registers all results into the ID/EX pipeline register that drives the execute stage; FlushE inserts a bubble.

---
 rtl/core_pkg.sv | 37 +++
 rtl/register_file.sv | 69 ++++++
 rtl/decode_cycle.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the MIPS-subset core: opcode/funct codes,
// ALU operation encoding and the control bundle carried down the pipe.
package core_pkg;

    // Primary opcodes (InstructionD[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // R-type function codes (InstructionD[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation encoding consumed by the execute stage
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Control bundle; an all-zero value is a bubble
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch;
        logic [2:0] alu_control;
        logic       alu_src;
        logic       reg_dst;
    } ctrl_t;

endpackage

// File: rtl/register_file.sv
// 2-read / 1-write register file with hard-wired zero register and
// write-through bypass so a value written back this cycle is visible to
// the instruction being decoded in the same cycle.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [ADDR_WIDTH-1:0] rd_addr [2];
    logic                  wr_valid;

    // A write to register 0 is architecturally a no-op
    assign wr_valid   = wr_en && (wr_addr != '0);
    assign rd_addr[0] = rd_addr1;
    assign rd_addr[1] = rd_addr2;

    // Next-state of the storage: only the addressed register changes
    always_comb begin
        regs_d = regs_q;
        if (wr_valid) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Storage update with synchronous clear of every register
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_read
            logic [DATA_WIDTH-1:0] data;
            // Read port: bypass first, then zero register, then storage
            always_comb begin
                if (wr_valid && (wr_addr == rd_addr[gi])) begin
                    data = wr_data;
                end else if (rd_addr[gi] == '0) begin
                    data = '0;
                end else begin
                    data = regs_q[rd_addr[gi]];
                end
            end
        end
    endgenerate

    assign rd_data1 = g_read[0].data;
    assign rd_data2 = g_read[1].data;

endmodule

// File: rtl/decode_cycle.sv
// Instruction-decode stage: register-file read, control and immediate
// generation, and the ID/EX pipeline register (with bubble insertion).
module decode_cycle
    import core_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               InstructionD,
    input  logic [DATA_WIDTH-1:0]     PCPlus4D,
    input  logic                      RegWriteW,
    input  logic [REG_ADDR_WIDTH-1:0] WriteRegW,
    input  logic [DATA_WIDTH-1:0]     ResultW,
    input  logic                      FlushE,
    output logic                      RegWriteE,
    output logic                      MemtoRegE,
    output logic                      MemWriteE,
    output logic                      BranchE,
    output logic                      ALUSrcE,
    output logic                      RegDstE,
    output logic [2:0]                ALUControlE,
    output logic [DATA_WIDTH-1:0]     RD1E,
    output logic [DATA_WIDTH-1:0]     RD2E,
    output logic [REG_ADDR_WIDTH-1:0] RsE,
    output logic [REG_ADDR_WIDTH-1:0] RtE,
    output logic [REG_ADDR_WIDTH-1:0] RdE,
    output logic [DATA_WIDTH-1:0]     SignImmE,
    output logic [DATA_WIDTH-1:0]     PCPlus4E
);
    logic [5:0]                opcode;
    logic [5:0]                funct;
    logic [REG_ADDR_WIDTH-1:0] rs;
    logic [REG_ADDR_WIDTH-1:0] rt;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     rd1;
    logic [DATA_WIDTH-1:0]     rd2;
    logic [DATA_WIDTH-1:0]     sign_imm;
    ctrl_t                     ctrl;

    ctrl_t                     ctrl_d,     ctrl_q;
    logic [DATA_WIDTH-1:0]     rd1_d,      rd1_q;
    logic [DATA_WIDTH-1:0]     rd2_d,      rd2_q;
    logic [REG_ADDR_WIDTH-1:0] rs_d,       rs_q;
    logic [REG_ADDR_WIDTH-1:0] rt_d,       rt_q;
    logic [REG_ADDR_WIDTH-1:0] rd_d,       rd_q;
    logic [DATA_WIDTH-1:0]     sign_imm_d, sign_imm_q;
    logic [DATA_WIDTH-1:0]     pc_plus4_d, pc_plus4_q;

    assign opcode   = InstructionD[31:26];
    assign funct    = InstructionD[5:0];
    assign rs       = InstructionD[25:21];
    assign rt       = InstructionD[20:16];
    assign rd       = InstructionD[15:11];
    assign sign_imm = {{(DATA_WIDTH-16){InstructionD[15]}}, InstructionD[15:0]};

    register_file #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_register_file (
        .clk     (clk),
        .rst     (rst),
        .rd_addr1(rs),
        .rd_addr2(rt),
        .rd_data1(rd1),
        .rd_data2(rd2),
        .wr_en   (RegWriteW),
        .wr_addr (WriteRegW),
        .wr_data (ResultW)
    );

    // Main/funct decode; unknown opcodes and unknown R-type functs are NOPs
    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.alu_control = ALU_ADD;
                    FN_SUB:  ctrl.alu_control = ALU_SUB;
                    FN_AND:  ctrl.alu_control = ALU_AND;
                    FN_OR:   ctrl.alu_control = ALU_OR;
                    FN_SLT:  ctrl.alu_control = ALU_SLT;
                    default: begin
                        ctrl.reg_write   = 1'b0;
                        ctrl.alu_control = ALU_AND;
                    end
                endcase
            end
            OP_LW: begin
                ctrl.reg_write   = 1'b1;
                ctrl.mem_to_reg  = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALU_ADD;
            end
            OP_SW: begin
                ctrl.mem_write   = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALU_ADD;
            end
            OP_BEQ: begin
                ctrl.branch      = 1'b1;
                ctrl.alu_control = ALU_SUB;
            end
            OP_ADDI: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALU_ADD;
            end
            default: ctrl = '0;
        endcase
    end

    // ID/EX next state: a flush replaces the whole entry with zeros
    always_comb begin
        ctrl_d     = ctrl;
        rd1_d      = rd1;
        rd2_d      = rd2;
        rs_d       = rs;
        rt_d       = rt;
        rd_d       = rd;
        sign_imm_d = sign_imm;
        pc_plus4_d = PCPlus4D;
        if (FlushE) begin
            ctrl_d     = '0;
            rd1_d      = '0;
            rd2_d      = '0;
            rs_d       = '0;
            rt_d       = '0;
            rd_d       = '0;
            sign_imm_d = '0;
            pc_plus4_d = '0;
        end
    end

    // ID/EX pipeline register; reset dominates flush
    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q     <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            sign_imm_q <= '0;
            pc_plus4_q <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            sign_imm_q <= sign_imm_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign RegWriteE   = ctrl_q.reg_write;
    assign MemtoRegE   = ctrl_q.mem_to_reg;
    assign MemWriteE   = ctrl_q.mem_write;
    assign BranchE     = ctrl_q.branch;
    assign ALUSrcE     = ctrl_q.alu_src;
    assign RegDstE     = ctrl_q.reg_dst;
    assign ALUControlE = ctrl_q.alu_control;
    assign RD1E        = rd1_q;
    assign RD2E        = rd2_q;
    assign RsE         = rs_q;
    assign RtE         = rt_q;
    assign RdE         = rd_q;
    assign SignImmE    = sign_imm_q;
    assign PCPlus4E    = pc_plus4_q;

endmodule
